// File: rtl/ow_pkg.sv
// ============================================================================
// Module      : ow_pkg
// Description : Shared state encoding, default timing and counter sizing for
//               the 1-Wire byte transaction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ow_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_LOW = 3'd1,
    RST_REC = 3'd2,
    SLOT    = 3'd3,
    DONE    = 3'd4
  } ow_state_e;

  localparam int c_slot_cycles        = 70;
  localparam int c_rst_low_cycles     = 480;
  localparam int c_rst_rec_cycles     = 480;
  localparam int c_pres_sample_cycles = 70;

  // Enough bits to hold the largest timing value, plus one bit of headroom.
  function automatic int ow_cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ow_cycle_timer.sv
// ============================================================================
// Module      : ow_cycle_timer
// Description : Loadable down-counter; expire is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ow_cycle_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign count  = r_count;
  assign expire = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ow_txn_ctrl.sv
// ============================================================================
// Module      : ow_txn_ctrl
// Description : 1-Wire byte transaction sequencer (optional reset/presence
//               phase, then eight LSB-first write slots for Master_tx).
//               Define OW_PRES_CHECK_EN to abort on a missing presence pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ow_txn_ctrl
  import ow_pkg::*;
#(
  parameter int SLOT_CYCLES        = c_slot_cycles,
  parameter int RST_LOW_CYCLES     = c_rst_low_cycles,
  parameter int RST_REC_CYCLES     = c_rst_rec_cycles,
  parameter int PRES_SAMPLE_CYCLES = c_pres_sample_cycles
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_reset,
  input  logic [7:0] cmd_data,
  output logic       tx_ready,
  output logic       tx_bit,
  output logic       bus_rst_low,
  input  logic       bus_in,
  output logic       presence,
  output logic       presence_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int c_cnt_w = ow_cnt_width(SLOT_CYCLES, RST_LOW_CYCLES,
                                        RST_REC_CYCLES, PRES_SAMPLE_CYCLES);

  localparam logic [c_cnt_w-1:0] c_slot_load  = c_cnt_w'(SLOT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_low_load   = c_cnt_w'(RST_LOW_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_rec_load   = c_cnt_w'(RST_REC_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_sample_cnt = c_cnt_w'(RST_REC_CYCLES - PRES_SAMPLE_CYCLES);

  if (SLOT_CYCLES < 62 || RST_LOW_CYCLES < 1 || PRES_SAMPLE_CYCLES < 0 ||
      PRES_SAMPLE_CYCLES >= RST_REC_CYCLES - 2) begin : g_param_check
    $error("ow_txn_ctrl: inconsistent timing parameters");
  end

  ow_state_e          r_state, w_state_nxt;
  logic               r_out_en;
  logic               r_bus_meta, r_bus_s;
  logic [7:0]         r_data;
  logic [2:0]         r_idx;
  logic               r_presence, r_pres_valid;
  logic               w_accept, w_sample, w_abort_now;
  logic               w_load, w_expire;
  logic [c_cnt_w-1:0] w_load_val, w_count;

  ow_cycle_timer #(
    .WIDTH(c_cnt_w)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .load_val(w_load_val),
    .count   (w_count),
    .expire  (w_expire)
  );

  assign w_accept = cmd_valid && cmd_ready;

  // The presence flop is updated one cycle early so that presence and
  // presence_valid appear together on the nominal sample cycle.
  if (PRES_SAMPLE_CYCLES == 0) begin : g_sample_early
    assign w_sample = (r_state == RST_LOW) && w_expire;
  end else begin : g_sample_rec
    assign w_sample = (r_state == RST_REC) && (w_count == c_sample_cnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_out_en     <= 1'b0;
      r_bus_meta   <= 1'b0;
      r_bus_s      <= 1'b0;
      r_data       <= 8'h00;
      r_idx        <= 3'd0;
      r_presence   <= 1'b0;
      r_pres_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_out_en     <= 1'b1;
      r_bus_meta   <= bus_in;
      r_bus_s      <= r_bus_meta;
      r_pres_valid <= w_sample;
      if (w_sample) r_presence <= ~r_bus_s;
      if (w_accept) begin
        r_data <= cmd_data;
        r_idx  <= 3'd0;
      end else if (r_state == SLOT && w_expire && r_idx != 3'd7) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (cmd_reset) begin
            w_state_nxt = RST_LOW;
            w_load_val  = c_low_load;
          end else begin
            w_state_nxt = SLOT;
            w_load_val  = c_slot_load;
          end
        end
      end
      RST_LOW: begin
        if (w_expire) begin
          w_state_nxt = RST_REC;
          w_load      = 1'b1;
          w_load_val  = c_rec_load;
        end
      end
      RST_REC: begin
        if (w_expire) begin
          if (w_abort_now) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = SLOT;
            w_load      = 1'b1;
            w_load_val  = c_slot_load;
          end
        end
      end
      SLOT: begin
        if (w_expire) begin
          if (r_idx == 3'd7) begin
            w_state_nxt = DONE;
          end else begin
            w_load     = 1'b1;
            w_load_val = c_slot_load;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef OW_PRES_CHECK_EN
  logic r_abort;

  assign w_abort_now = (r_state == RST_REC) && w_expire && !r_presence;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_abort <= 1'b0;
    end else if (w_accept) begin
      r_abort <= 1'b0;
    end else if (w_abort_now) begin
      r_abort <= 1'b1;
    end
  end

  assign done = (r_state == DONE) && !r_abort;
  assign err  = (r_state == DONE) && r_abort;
`else
  assign w_abort_now = 1'b0;
  assign done        = (r_state == DONE);
  assign err         = 1'b0;
`endif

  // cmd_ready is withheld until the first clock after reset release.
  assign cmd_ready      = r_out_en && (r_state == IDLE);
  assign tx_ready       = (r_state == SLOT) && (w_count == c_slot_load);
  assign tx_bit         = (r_state == SLOT) && r_data[r_idx];
  assign bus_rst_low    = (r_state == RST_LOW);
  assign busy           = (r_state == RST_LOW) || (r_state == RST_REC) || (r_state == SLOT);
  assign presence       = r_presence;
  assign presence_valid = r_pres_valid;

endmodule

`default_nettype wire

// File: tb/tb_ow_txn_ctrl.sv
// ============================================================================
// Module      : tb_ow_txn_ctrl
// Description : Randomized bench for ow_txn_ctrl against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ow_txn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_reset = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       bus_in = 1'b1;
  logic       cmd_ready, tx_ready, tx_bit, bus_rst_low;
  logic       presence, presence_valid, busy, done, err;

  ow_txn_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_reset     (cmd_reset),
    .cmd_data      (cmd_data),
    .tx_ready      (tx_ready),
    .tx_bit        (tx_bit),
    .bus_rst_low   (bus_rst_low),
    .bus_in        (bus_in),
    .presence      (presence),
    .presence_valid(presence_valid),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

`ifdef OW_PRES_CHECK_EN
  localparam bit c_check_en = 1'b1;
`else
  localparam bit c_check_en = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference timeline state for the transaction in flight.
  bit         ready_en = 1'b0;
  bit         in_txn   = 1'b0;
  int         t_acc    = 0;
  bit         m_rst    = 1'b0;
  bit         m_dev    = 1'b0;
  bit         m_abort  = 1'b0;
  bit         m_pres   = 1'b0;
  logic [7:0] m_data   = 8'h00;
  int         end_t    = 0;
  int         acc_cnt  = 0;

  // Pending command generator state.
  bit         pend     = 1'b0;
  logic [7:0] p_data   = 8'h00;
  bit         p_rst    = 1'b0;
  bit         p_dev    = 1'b0;
  int         n_gen    = 0;
  bit         rel_pend = 1'b0;
  bit         mid_done = 1'b0;

  int         t, s, lead;
  logic [8:0] ev;

  task automatic check_vec(input string tag, input logic [8:0] obs, input logic [8:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b want %b (rdy txr txb rstl pres pv busy done err)",
               tag, cyc, obs, want);
    end
  endtask

  function automatic logic [8:0] dut_out();
    return {cmd_ready, tx_ready, tx_bit, bus_rst_low, presence, presence_valid, busy, done, err};
  endfunction

  task automatic gen_cmd();
    pend = 1'b1;
    case (n_gen)
      0: begin p_data = 8'hA5; p_rst = 1'b0; p_dev = 1'b0; end
      1: begin p_data = 8'h00; p_rst = 1'b1; p_dev = 1'b1; end
      2: begin p_data = 8'($urandom); p_rst = 1'b1; p_dev = 1'b0; end
      3: begin p_data = 8'($urandom); p_rst = 1'b1; p_dev = 1'b1; end
      4: begin p_data = 8'($urandom); p_rst = 1'b0; p_dev = 1'b0; end
      default: begin
        p_data = 8'($urandom);
        p_rst  = ($urandom_range(0, 2) == 0);
        p_dev  = 1'($urandom_range(0, 1));
      end
    endcase
    n_gen++;
  endtask

  initial begin
    repeat (3) begin
      @(posedge clk); #1; cyc++;
      @(negedge clk);
      check_vec("reset_hold", dut_out(), 9'b0);
    end
    rel_pend = 1'b1;

    while (cyc < 30000) begin
      @(posedge clk); #1; cyc++;
      if (rel_pend) begin
        rst      = 1'b1;
        rel_pend = 1'b0;
      end
      if (!pend && $urandom_range(0, 3) == 0) gen_cmd();
      cmd_valid = pend;
      if (pend) begin
        cmd_data  = p_data;
        cmd_reset = p_rst;
      end else begin
        cmd_data  = 8'($urandom);
        cmd_reset = 1'($urandom);
      end
      t      = cyc - t_acc;
      bus_in = !(in_txn && m_rst && m_dev && t >= 481 && t <= 960);

      @(negedge clk);
      if (in_txn && t == end_t + 1) in_txn = 1'b0;
      ev = '0;
      if (!in_txn) begin
        ev[8] = ready_en;
      end else begin
        lead = m_rst ? 960 : 0;
        if (m_rst && t == 551) begin
          m_pres = m_dev;
          ev[3]  = 1'b1;
        end
        ev[5] = m_rst && t >= 1 && t <= 480;
        if (!m_abort && t >= lead + 1 && t <= lead + 560) begin
          s     = t - lead - 1;
          ev[7] = (s % 70 == 0);
          ev[6] = m_data[s / 70];
        end
        ev[2] = (t >= 1) && (t < end_t);
        ev[1] = !m_abort && (t == end_t);
        ev[0] = m_abort && (t == end_t);
      end
      ev[4] = m_pres;
      check_vec(in_txn ? "txn" : "idle", dut_out(), ev);

      if (!in_txn && ev[8] && cmd_valid) begin
        in_txn  = 1'b1;
        t_acc   = cyc;
        m_data  = cmd_data;
        m_rst   = cmd_reset;
        m_dev   = p_dev;
        m_abort = c_check_en && cmd_reset && !p_dev;
        lead    = cmd_reset ? 960 : 0;
        end_t   = m_abort ? lead + 1 : lead + 561;
        acc_cnt++;
        pend    = 1'b0;
      end
      ready_en = 1'b1;

      // Asynchronous reset in the middle of slot 3 of a byte-only transaction.
      if (in_txn && acc_cnt == 5 && !mid_done && !m_rst && (cyc - t_acc) == 221) begin
        #2 rst = 1'b0;
        #1 check_vec("async_rst", dut_out(), 9'b0);
        in_txn    = 1'b0;
        m_pres    = 1'b0;
        ready_en  = 1'b0;
        pend      = 1'b0;
        cmd_valid = 1'b0;
        mid_done  = 1'b1;
        repeat (3) begin
          @(posedge clk); #1; cyc++;
          @(negedge clk);
          check_vec("in_reset", dut_out(), 9'b0);
        end
        rel_pend = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ow_txn_ctrl.md
Name: ow_txn_ctrl

Overview:
Byte-level 1-Wire transaction sequencer sitting directly above the bit transmitter Master_tx.
- Accepts one command byte at a time, with an optional reset/presence phase before it.
- Schedules the eight write slots LSB first by driving the transmitter's ready/bit_to_send inputs on a fixed slot grid.
- Generates the reset low pulse on the bus and samples the presence response.

Parameters:
SLOT_CYCLES, 70, clocks from one slot start to the next; must be >= 62 (60 low + recovery)
RST_LOW_CYCLES, 480, clocks bus_rst_low is held high during a reset phase
RST_REC_CYCLES, 480, clocks of released bus after reset low, before first slot
PRES_SAMPLE_CYCLES, 70, offset into the recovery window at which bus_in is sampled; must be < RST_REC_CYCLES - 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_reset  in  1  perform reset/presence phase before the byte
cmd_data  in  8  byte to transmit, bit 0 first
tx_ready  out  1  slot-start strobe to Master_tx ready
tx_bit  out  1  bit to Master_tx bit_to_send
bus_rst_low  out  1  forces bus low during reset pulse; externally ANDed inverted with bus_out
bus_in  in  1  asynchronous bus readback
presence  out  1  last sampled presence (1 = device pulled low)
presence_valid  out  1  one-cycle pulse when presence updates
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at transaction end
err  out  1  one-cycle pulse, no-presence abort (see Optional Feature)

Behaviour:
- Reset (rst=0) is immediate and asynchronous for every state. All outputs are 0, cmd_ready included; state goes to IDLE. cmd_ready rises the first clock after rst deasserts. Reset mid-slot or mid-reset-pulse abandons the transaction, with no done pulse.
- bus_in passes through a 2-flop synchronizer; sampled value = bus_in_s.
- States: IDLE, RST_LOW, RST_REC, SLOT, DONE. A single shared down-counter times every state.
- IDLE: cmd_ready=1. Handshake at cycle T when cmd_valid && cmd_ready. At acceptance, cmd_data and cmd_reset are latched, the bit index is cleared, and busy=1 from T+1.
  - cmd_reset=1: go to RST_LOW.
  - cmd_reset=0: go to SLOT.
- RST_LOW: bus_rst_low=1 for exactly RST_LOW_CYCLES cycles (T+1 .. T+RST_LOW_CYCLES), then go to RST_REC.
- RST_REC: bus_rst_low=0 for RST_REC_CYCLES cycles.
  - On recovery cycle PRES_SAMPLE_CYCLES (counting from 0): presence <= ~bus_in_s and presence_valid=1 for that cycle.
  - At the end of recovery, go to SLOT.
- SLOT: tx_ready=1 for exactly one cycle at each slot start. tx_bit = latched data[idx] and is held stable for the whole slot.
  - Slot idx starts SLOT_CYCLES after slot idx-1.
  - Without reset phase, the first slot starts at T+1.
  - After the slot for idx=7 expires, go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE. The earliest next acceptance is the cycle after done.
- Commands are not queued; cmd_valid while busy is ignored and holds until cmd_ready.
- presence is held between reset phases; it is not cleared by a byte-only transaction.
- Counter width: clog2 of the max parameter + 1. Parameters must be consistent (checked by an elaboration-time assertion).

Optional Feature:
Macro OW_PRES_CHECK_EN.
- Defined: if the presence sample in RST_REC reads 0 (no device), the transaction aborts at the end of RST_REC. No slots are issued; err=1 for one cycle in place of done, busy=0, then IDLE.
- Undefined: the byte is always transmitted regardless of presence. err is tied 0.

Decomposition:
Package ow_pkg holds:
- the state enum (IDLE, RST_LOW, RST_REC, SLOT, DONE);
- the default timing constants (slot, reset low, recovery, sample offset);
- a shared counter-width function.

Natural sub-module: ow_cycle_timer. It is a loadable down-counter with an expire pulse and a current-count output, used for all state timing.

Test Plan:
- Reset then idle: hold rst=0 three cycles, release, cmd_valid=0. Required: cmd_ready=1 from the next cycle; tx_ready, bus_rst_low, busy, done all 0 for 100 cycles.
- Byte only: cmd_data=8'hA5, cmd_reset=0, accepted at T. Required: tx_ready pulses at T+1+70k for k=0..7, tx_bit sequence 1,0,1,0,0,1,0,1; done at T+561; cmd_ready=1 at T+562.
- Reset with presence: cmd_reset=1, cmd_data=8'h00, bus_in driven 0 during recovery. Required: bus_rst_low high T+1..T+480; presence_valid at T+551 with presence=1; first tx_ready at T+961; done at T+1521.
- No presence with OW_PRES_CHECK_EN: bus_in held 1. Required: presence=0; err pulse at T+961; tx_ready never asserted; done never asserted.
- Busy backpressure: assert a second cmd_valid at T+100 and hold it. Required: cmd_ready stays 0 until after done; the second command is accepted in the first IDLE cycle.
- Reset mid-slot: drop rst during slot 3. Required: tx_ready=0, busy=0, bus_rst_low=0 immediately; no done pulse; clean new transaction after release.
